// File: rtl/sobel_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sobel_pkg
//  Description : Shared types and constants for the sobel_hls run-time
//                sequencer: FSM state encoding and default image geometry.
//  Revision    : 1.0 - initial release
// ============================================================================
package sobel_pkg;

  // Default geometry; must track the sobel_hls synthesis constants.
  localparam int unsigned DEF_IMG_W   = 64;
  localparam int unsigned DEF_IMG_H   = 64;
  localparam int unsigned FRAME_BEATS = DEF_IMG_W * DEF_IMG_H;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_RUN       = 3'd2,
    ST_WAIT_IDLE = 3'd3,
    ST_DONE      = 3'd4,
    ST_STALL     = 3'd5
  } seq_state_e;

  // A run is in flight from the first ap_start until the core reports idle.
  function automatic logic state_is_busy(input seq_state_e s);
    return (s == ST_START) || (s == ST_RUN) || (s == ST_WAIT_IDLE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sobel_progress_wdog.sv
`default_nettype none
// ============================================================================
//  Module      : sobel_progress_wdog
//  Description : No-progress watchdog. Counts enabled cycles without progress
//                and flags expiry after exactly LIMIT such cycles. A limit of
//                zero disables expiry.
//  Revision    : 1.0 - initial release
// ============================================================================
module sobel_progress_wdog #(
  parameter int WDOG_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic              i_progress,
  input  logic              i_clr,
  input  logic [WDOG_W-1:0] i_limit,
  output logic              o_expire
);

  logic [WDOG_W-1:0] cnt_q;
  logic [WDOG_W-1:0] cnt_d;

  // Progress in the current cycle always wins over expiry; >= keeps the
  // watchdog able to fire if the limit is lowered while counting.
  assign o_expire = i_en && (i_limit != '0) && !i_progress &&
                    (cnt_q >= (i_limit - 1'b1));

  // Next count: clear on progress or external clear, else saturating increment.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clr || i_progress) begin
      cnt_d = '0;
    end else if (i_en && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sobel_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : sobel_frame_sequencer
//  Description : Run-time controller for sobel_hls. Issues one ap_start per
//                frame for a programmed frame count, taps the input/output
//                AXIS handshakes to check per-frame beat totals, and flags a
//                stream deadlock through a progress watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
module sobel_frame_sequencer
  import sobel_pkg::*;
#(
  parameter int IMG_W   = DEF_IMG_W,
  parameter int IMG_H   = DEF_IMG_H,
  parameter int BEAT_W  = 16,
  parameter int FRAME_W = 8,
  parameter int WDOG_W  = 16
) (
  input  logic               ap_clk,
  input  logic               ap_rst,
  input  logic [FRAME_W-1:0] cfg_frames,
  input  logic [WDOG_W-1:0]  cfg_wdog_limit,
  input  logic               cmd_start,
  input  logic               cmd_abort,
  output logic               core_ap_start,
  input  logic               core_ap_ready,
  input  logic               core_ap_done,
  input  logic               core_ap_idle,
  input  logic               s_tvalid,
  input  logic               s_tready,
  input  logic               m_tvalid,
  input  logic               m_tready,
  output logic               busy,
  output logic [FRAME_W-1:0] frame_cnt,
  output logic               run_done,
  output logic               err_deadlock,
  output logic               err_beats
);

  localparam logic [BEAT_W-1:0] c_frame_beats = BEAT_W'(IMG_W * IMG_H);

  seq_state_e         state_q,        state_d;
  logic [FRAME_W-1:0] frames_q,       frames_d;
  logic [FRAME_W-1:0] frame_cnt_q,    frame_cnt_d;
  logic [BEAT_W-1:0]  in_cnt_q,       in_cnt_d;
  logic [BEAT_W-1:0]  out_cnt_q,      out_cnt_d;
  logic               ap_start_q,     ap_start_d;
  logic               run_done_q,     run_done_d;
  logic               err_deadlock_q, err_deadlock_d;
  logic               err_beats_q,    err_beats_d;

  logic               w_in_beat;
  logic               w_out_beat;
  logic               w_counting;
  logic               w_progress;
  logic               w_wd_expire;
  logic [BEAT_W-1:0]  w_in_next;
  logic [BEAT_W-1:0]  w_out_next;
  logic [FRAME_W:0]   w_frame_inc;

  assign w_in_beat  = s_tvalid & s_tready;
  assign w_out_beat = m_tvalid & m_tready;
  // Beats may start before ap_ready, so START counts as well as RUN.
  assign w_counting = (state_q == ST_START) || (state_q == ST_RUN);
  // The ap_ready handshake is forward motion too, so it cannot coincide with a stall.
  assign w_progress = w_in_beat | w_out_beat | core_ap_done |
                      ((state_q == ST_START) & core_ap_ready);

  // Saturating beat counts including any beat in the current cycle.
  assign w_in_next   = (w_in_beat  && (in_cnt_q  != '1)) ? in_cnt_q  + 1'b1 : in_cnt_q;
  assign w_out_next  = (w_out_beat && (out_cnt_q != '1)) ? out_cnt_q + 1'b1 : out_cnt_q;
  assign w_frame_inc = {1'b0, frame_cnt_q} + 1'b1;

  sobel_progress_wdog #(
    .WDOG_W (WDOG_W)
  ) u_wdog (
    .clk        (ap_clk),
    .rst        (ap_rst),
    .i_en       (w_counting),
    .i_progress (w_progress),
    .i_clr      (state_d != state_q),
    .i_limit    (cfg_wdog_limit),
    .o_expire   (w_wd_expire)
  );

  // Next-state, counter and flag logic; abort overrides every other event.
  always_comb begin
    state_d        = state_q;
    frames_d       = frames_q;
    frame_cnt_d    = frame_cnt_q;
    in_cnt_d       = in_cnt_q;
    out_cnt_d      = out_cnt_q;
    err_deadlock_d = err_deadlock_q;
    err_beats_d    = err_beats_q;

    if (w_counting) begin
      in_cnt_d  = w_in_next;
      out_cnt_d = w_out_next;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (cmd_start) begin
          state_d        = ST_START;
          frames_d       = (cfg_frames == '0) ? FRAME_W'(1) : cfg_frames;
          frame_cnt_d    = '0;
          in_cnt_d       = '0;
          out_cnt_d      = '0;
          err_deadlock_d = 1'b0;
          err_beats_d    = 1'b0;
        end
      end
      ST_START: begin
        if (core_ap_ready) begin
          state_d = ST_RUN;
        end else if (w_wd_expire) begin
          state_d        = ST_STALL;
          err_deadlock_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (core_ap_done) begin
          if ((w_in_next != c_frame_beats) || (w_out_next != c_frame_beats)) begin
            err_beats_d = 1'b1;
          end
          frame_cnt_d = frame_cnt_q + 1'b1;
          in_cnt_d    = '0;
          out_cnt_d   = '0;
          state_d     = (w_frame_inc == {1'b0, frames_q}) ? ST_WAIT_IDLE : ST_START;
        end else if (w_wd_expire) begin
          state_d        = ST_STALL;
          err_deadlock_d = 1'b1;
        end
      end
      ST_WAIT_IDLE: begin
        if (core_ap_idle) begin
          state_d = ST_DONE;
        end
      end
      ST_STALL: begin
        state_d = ST_STALL;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (cmd_abort) begin
      state_d     = ST_IDLE;
      frames_d    = '0;
      frame_cnt_d = '0;
      in_cnt_d    = '0;
      out_cnt_d   = '0;
    end

    // ap_start is registered: high for every cycle spent in START.
    ap_start_d = (state_d == ST_START);
    run_done_d = (state_d == ST_DONE) && (state_q != ST_DONE);
  end

  // State and datapath registers.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q        <= ST_IDLE;
      frames_q       <= '0;
      frame_cnt_q    <= '0;
      in_cnt_q       <= '0;
      out_cnt_q      <= '0;
      ap_start_q     <= 1'b0;
      run_done_q     <= 1'b0;
      err_deadlock_q <= 1'b0;
      err_beats_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      frames_q       <= frames_d;
      frame_cnt_q    <= frame_cnt_d;
      in_cnt_q       <= in_cnt_d;
      out_cnt_q      <= out_cnt_d;
      ap_start_q     <= ap_start_d;
      run_done_q     <= run_done_d;
      err_deadlock_q <= err_deadlock_d;
      err_beats_q    <= err_beats_d;
    end
  end

  assign core_ap_start = ap_start_q;
  assign busy          = state_is_busy(state_q);
  assign frame_cnt     = frame_cnt_q;
  assign run_done      = run_done_q;
  assign err_deadlock  = err_deadlock_q;
  assign err_beats     = err_beats_q;

endmodule
`default_nettype wire
